pt_vc_fifo: RTL and testbench

Multi-channel ring-stop buffer that generalises the two-entry register FIFO to NUM_VC independent virtual-channel queues.
- Each queue is DEPTH entries deep; queues share one write port and one read port, each with a VC index.
- Sits between the ring link and the local ejection/injection arbiter in PtRing.
- Provides per-VC full/empty/almost-full flags and occupancy for credit-style backpressure.

---
 rtl/pt_vc_fifo_if.sv | 35 +++
 rtl/pt_vc_fifo.sv | 125 ++++++++++++
 tb/tb_pt_vc_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pt_vc_fifo_if.sv
// Write/read/flag bundle for pt_vc_fifo.
// The master side drives the i_* fields and the slave side drives the o_* fields.
interface pt_vc_fifo_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int NUM_VC = 2
);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic                 i_wr_en;
    logic [VCW-1:0]       i_wr_vc;
    logic [WIDTH-1:0]     i_wr_dat;
    logic                 i_rd_en;
    logic [VCW-1:0]       i_rd_vc;
    logic                 i_err_clr;
    logic [WIDTH-1:0]     o_rd_dat;
    logic                 o_rd_vld;
    logic [NUM_VC-1:0]    o_ful;
    logic [NUM_VC-1:0]    o_empty;
    logic [NUM_VC-1:0]    o_afull;
    logic [NUM_VC*CW-1:0] o_cnt;
    logic [NUM_VC-1:0]    o_ovf;
    logic [NUM_VC-1:0]    o_udf;

    modport master (
        output i_wr_en, i_wr_vc, i_wr_dat, i_rd_en, i_rd_vc, i_err_clr,
        input  o_rd_dat, o_rd_vld, o_ful, o_empty, o_afull, o_cnt, o_ovf, o_udf
    );

    modport slave (
        input  i_wr_en, i_wr_vc, i_wr_dat, i_rd_en, i_rd_vc, i_err_clr,
        output o_rd_dat, o_rd_vld, o_ful, o_empty, o_afull, o_cnt, o_ovf, o_udf
    );
endinterface

// File: rtl/pt_vc_fifo.sv
// Ring-stop buffer holding NUM_VC independent show-ahead FIFOs behind one write port and one read port.
// Defining PT_VC_FIFO_BYPASS_EN adds a combinational write-to-read path when the selected VC is empty.
module pt_vc_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int NUM_VC   = 2,
    parameter int AFULL_TH = 3
) (
    input  logic           clk,
    input  logic           rst,
    pt_vc_fifo_if.slave    bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  r_mem    [NUM_VC][DEPTH];
    logic [PW-1:0]     r_rd_ptr [NUM_VC];
    logic [PW-1:0]     r_wr_ptr [NUM_VC];
    logic [CW-1:0]     r_cnt    [NUM_VC];
    logic [NUM_VC-1:0] r_ful;
    logic [NUM_VC-1:0] r_empty;
    logic [NUM_VC-1:0] r_afull;
    logic [NUM_VC-1:0] r_ovf;
    logic [NUM_VC-1:0] r_udf;

    logic              w_wr_ok;
    logic              w_rd_vc_ok;
    logic [VCW-1:0]    w_rd_idx;
    logic              w_byp;
    logic [NUM_VC-1:0] w_wr_hit;
    logic [NUM_VC-1:0] w_rd_hit;
    logic [NUM_VC-1:0] w_thru;
    logic [NUM_VC-1:0] w_store;
    logic [NUM_VC-1:0] w_pop;
    logic [NUM_VC-1:0] w_ovf_evt;
    logic [NUM_VC-1:0] w_udf_evt;
    logic [CW-1:0]     w_cnt_nxt [NUM_VC];

    assign w_wr_ok    = bus.i_wr_en && ({{(32-VCW){1'b0}}, bus.i_wr_vc} < 32'(NUM_VC));
    assign w_rd_vc_ok = {{(32-VCW){1'b0}}, bus.i_rd_vc} < 32'(NUM_VC);
    assign w_rd_idx   = w_rd_vc_ok ? bus.i_rd_vc : '0;

`ifdef PT_VC_FIFO_BYPASS_EN
    // An empty VC is never full, so a same-VC write here is always accepted.
    assign w_byp = w_wr_ok && w_rd_vc_ok && (bus.i_wr_vc == bus.i_rd_vc) && r_empty[w_rd_idx];
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
        w_wr_hit  = '0;
        w_rd_hit  = '0;
        w_thru    = '0;
        w_store   = '0;
        w_pop     = '0;
        w_ovf_evt = '0;
        w_udf_evt = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_wr_hit[v]  = w_wr_ok && (bus.i_wr_vc == VCW'(v));
            w_rd_hit[v]  = bus.i_rd_en && w_rd_vc_ok && (bus.i_rd_vc == VCW'(v));
            w_thru[v]    = w_byp && w_rd_hit[v];
            w_store[v]   = w_wr_hit[v] && !r_ful[v] && !w_thru[v];
            w_pop[v]     = w_rd_hit[v] && !r_empty[v];
            w_ovf_evt[v] = w_wr_hit[v] && r_ful[v];
            w_udf_evt[v] = w_rd_hit[v] && r_empty[v] && !w_thru[v];
            w_cnt_nxt[v] = r_cnt[v] + CW'(w_store[v]) - CW'(w_pop[v]);
        end
    end

    always_comb begin
        bus.o_rd_vld = w_rd_vc_ok && !r_empty[w_rd_idx];
        bus.o_rd_dat = r_mem[w_rd_idx][r_rd_ptr[w_rd_idx]];
        if (w_byp) begin
            bus.o_rd_vld = 1'b1;
            bus.o_rd_dat = bus.i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_rd_ptr[v] <= '0;
                r_wr_ptr[v] <= '0;
                r_cnt[v]    <= '0;
            end
            r_ful   <= '0;
            r_empty <= '1;
            r_afull <= '0;
            r_ovf   <= '0;
            r_udf   <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_store[v]) r_wr_ptr[v] <= r_wr_ptr[v] + PW'(1);
                if (w_pop[v])   r_rd_ptr[v] <= r_rd_ptr[v] + PW'(1);
                r_cnt[v]   <= w_cnt_nxt[v];
                r_ful[v]   <= (w_cnt_nxt[v] == CW'(DEPTH));
                r_empty[v] <= (w_cnt_nxt[v] == '0);
                r_afull[v] <= (w_cnt_nxt[v] >= CW'(AFULL_TH));
            end
            // A new error event outranks a clear in the same cycle.
            r_ovf <= (bus.i_err_clr ? '0 : r_ovf) | w_ovf_evt;
            r_udf <= (bus.i_err_clr ? '0 : r_udf) | w_udf_evt;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_store[v]) r_mem[v][r_wr_ptr[v]] <= bus.i_wr_dat;
        end
    end

    always_comb begin
        bus.o_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            bus.o_cnt[v*CW +: CW] = r_cnt[v];
        end
    end

    assign bus.o_ful   = r_ful;
    assign bus.o_empty = r_empty;
    assign bus.o_afull = r_afull;
    assign bus.o_ovf   = r_ovf;
    assign bus.o_udf   = r_udf;
endmodule

// File: tb/tb_pt_vc_fifo.sv
// Directed bench for pt_vc_fifo with DEPTH=4, NUM_VC=2 and AFULL_TH=3; popped data is scored against per-VC expected queues.
// Runs the bypass case when PT_VC_FIFO_BYPASS_EN is defined, otherwise the no-bypass case.
module tb_pt_vc_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    pt_vc_fifo_if #(.WIDTH(32), .DEPTH(4), .NUM_VC(2)) bus();

    pt_vc_fifo #(.WIDTH(32), .DEPTH(4), .NUM_VC(2), .AFULL_TH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.i_wr_en   = 1'b0;
        bus.i_wr_vc   = 1'b0;
        bus.i_wr_dat  = '0;
        bus.i_rd_en   = 1'b0;
        bus.i_rd_vc   = 1'b0;
        bus.i_err_clr = 1'b0;
    endtask

    // One clock of stimulus; ex_push says the bench expects the write to land in the queue.
    task automatic cyc(input logic we, input logic wv, input logic [31:0] wd,
                       input logic re, input logic rv, input logic ex_push, input logic clr);
        bus.i_wr_en   = we;
        bus.i_wr_vc   = wv;
        bus.i_wr_dat  = wd;
        bus.i_rd_en   = re;
        bus.i_rd_vc   = rv;
        bus.i_err_clr = clr;
        if (ex_push) begin
            if (wv) q1.push_back(wd);
            else    q0.push_back(wd);
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: every accepted pop must return the oldest expected flit of that VC.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.i_rd_en && bus.o_rd_vld) begin
                if ((bus.i_rd_vc ? q1.size() : q0.size()) == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pop_unexpected vc=%0d actual=%0h required=no_flit t=%0t",
                             bus.i_rd_vc, bus.o_rd_dat, $time);
                end else begin
                    mon_exp = bus.i_rd_vc ? q1.pop_front() : q0.pop_front();
                    chk("rd_dat", {32'h0, bus.o_rd_dat}, {32'h0, mon_exp});
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_empty", bus.o_empty, 2'b11);
        chk("rst_ful",   bus.o_ful,   2'b00);
        chk("rst_afull", bus.o_afull, 2'b00);
        chk("rst_cnt",   bus.o_cnt,   6'd0);
        chk("rst_ovf",   bus.o_ovf,   2'b00);
        chk("rst_udf",   bus.o_udf,   2'b00);
        chk("rst_vld",   bus.o_rd_vld, 1'b0);

        // Fill VC0 to full, then overflow it.
        cyc(1, 0, 32'h11, 0, 0, 1, 0);
        chk("head_vld", bus.o_rd_vld, 1'b1);
        chk("head_dat", bus.o_rd_dat, 32'h11);
        chk("cnt0_1",   bus.o_cnt[2:0], 3'd1);
        cyc(1, 0, 32'h22, 0, 0, 1, 0);
        chk("afull_2",  bus.o_afull, 2'b00);
        cyc(1, 0, 32'h33, 0, 0, 1, 0);
        chk("afull_3",  bus.o_afull, 2'b01);
        chk("cnt0_3",   bus.o_cnt[2:0], 3'd3);
        chk("ful_3",    bus.o_ful, 2'b00);
        cyc(1, 0, 32'h44, 0, 0, 1, 0);
        chk("ful_4",    bus.o_ful, 2'b01);
        chk("cnt_4",    bus.o_cnt, 6'b000_100);
        cyc(1, 0, 32'h55, 0, 0, 0, 0);
        chk("ovf_set",  bus.o_ovf, 2'b01);
        chk("cnt0_ovf", bus.o_cnt[2:0], 3'd4);
        chk("head_ovf", bus.o_rd_dat, 32'h11);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_clr",  bus.o_ovf, 2'b00);

        // Drain VC0, then underflow it.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0, 0);
        chk("drain_empty", bus.o_empty, 2'b11);
        chk("drain_cnt0",  bus.o_cnt[2:0], 3'd0);
        chk("drain_vld",   bus.o_rd_vld, 1'b0);
        chk("drain_ful",   bus.o_ful, 2'b00);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("udf_set",     bus.o_udf, 2'b01);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("udf_clr",     bus.o_udf, 2'b00);

        // Interleave VC0/VC1 writes while popping VC1.
        cyc(1, 0, 32'hA0, 0, 0, 1, 0);
        cyc(1, 1, 32'hB0, 0, 1, 1, 0);
        cyc(1, 0, 32'hA1, 0, 0, 1, 0);
        cyc(1, 1, 32'hB1, 1, 1, 1, 0);
        chk("il_cnt1",  bus.o_cnt[5:3], 3'd1);
        cyc(1, 0, 32'hA2, 1, 1, 1, 0);
        chk("il_cnt",   bus.o_cnt, 6'b000_011);
        chk("il_empty", bus.o_empty, 2'b10);
        chk("il_afull", bus.o_afull, 2'b01);

        // Steady write+pop on VC1 at occupancy 2 across pointer wrap.
        cyc(1, 1, 32'hB2, 0, 1, 1, 0);
        cyc(1, 1, 32'hB3, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 32'hC0 + 32'(i), 1, 1, 1, 0);
            chk("steady_cnt1", bus.o_cnt[5:3], 3'd2);
        end
        chk("steady_cnt0", bus.o_cnt[2:0], 3'd3);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("vc1_udf",  bus.o_udf, 2'b10);
        chk("vc1_cnt",  bus.o_cnt[5:3], 3'd0);

        // Reset with VC0 holding three flits.
        chk("pre_rst_cnt0", bus.o_cnt[2:0], 3'd3);
        rst = 1'b0;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
        chk("mid_rst_empty", bus.o_empty, 2'b11);
        chk("mid_rst_cnt",   bus.o_cnt, 6'd0);
        chk("mid_rst_ovf",   bus.o_ovf, 2'b00);
        chk("mid_rst_udf",   bus.o_udf, 2'b00);
        chk("mid_rst_afull", bus.o_afull, 2'b00);
        rst = 1'b1;

        // Same-cycle write and pop on empty VC0.
        bus.i_wr_en  = 1'b1;
        bus.i_wr_vc  = 1'b0;
        bus.i_wr_dat = 32'h5A;
        bus.i_rd_en  = 1'b1;
        bus.i_rd_vc  = 1'b0;
        q0.push_back(32'h5A);
        #1;
`ifdef PT_VC_FIFO_BYPASS_EN
        chk("byp_vld", bus.o_rd_vld, 1'b1);
        chk("byp_dat", bus.o_rd_dat, 32'h5A);
        @(posedge clk);
        #1;
        idle();
        chk("byp_empty", bus.o_empty, 2'b11);
        chk("byp_cnt0",  bus.o_cnt[2:0], 3'd0);
        chk("byp_udf",   bus.o_udf, 2'b00);
`else
        chk("nobyp_vld", bus.o_rd_vld, 1'b0);
        @(posedge clk);
        #1;
        idle();
        chk("nobyp_empty", bus.o_empty, 2'b10);
        chk("nobyp_cnt0",  bus.o_cnt[2:0], 3'd1);
        chk("nobyp_udf",   bus.o_udf, 2'b01);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("nobyp_drain", bus.o_empty, 2'b11);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("q0_left", 64'(q0.size()), 64'd0);
        chk("q1_left", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
